// File: rtl/vc_rr_arb_mux_if.sv
// Bundle of the N-input arbitrated mux's input and output channels.
//
// Handshake: on every channel a transfer happens on a rising clock edge where
// valid and ready are both high. A producer that raises valid keeps valid and
// its message stable until that transfer. Ready may depend on valid (through
// arbitration), but valid never depends on ready.
interface vc_rr_arb_mux_if #(
  parameter int p_nbits     = 16,
  parameter int p_nports    = 4,
  parameter int p_sel_nbits = $clog2(p_nports)
);
  logic [p_nports-1:0]         in_val;
  logic [p_nports-1:0]         in_rdy;
  logic [p_nports*p_nbits-1:0] in_msg;
  logic                        out_val;
  logic                        out_rdy;
  logic [p_nbits-1:0]          out_msg;
  logic [p_sel_nbits-1:0]      out_sel;

  // Producers of the input messages and the single consumer.
  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_sel
  );

  // The arbiter/mux itself.
  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_sel
  );
endinterface

// File: rtl/vc_rr_arb_mux.sv
// Round-robin arbitrated N:1 mux with one registered output stage.
// The port that wins a transfer becomes lowest priority for the next one,
// so every requester is served within N transfers.
module vc_rr_arb_mux #(
  parameter int p_nbits     = 16,
  parameter int p_nports    = 4,
  parameter int p_sel_nbits = $clog2(p_nports)
) (
  input logic             clk,
  input logic             reset,
  vc_rr_arb_mux_if.slave  bus
);

  // Priority pointer: the port scanned first by the arbiter.
  logic [p_sel_nbits-1:0] ptr;
  logic [p_sel_nbits-1:0] ptr_nxt;
  logic [p_sel_nbits-1:0] grant_idx;
  logic                   grant_any;
  logic                   out_go;
  logic                   xfer;

  // Output register is empty or is being drained this cycle.
  assign out_go = !bus.out_val || bus.out_rdy;

  // Arbitration: first valid port scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < p_nports; k++) begin
      if (!grant_any && bus.in_val[(int'(ptr) + k) % p_nports]) begin
        grant_any = 1'b1;
        grant_idx = p_sel_nbits'((int'(ptr) + k) % p_nports);
      end
    end
  end

  // A transfer needs a winner and room in the output register; reset blocks it.
  assign xfer = grant_any && out_go && !reset;

  // Winner is lowest priority next time; wrap explicitly for non-power-of-2 N.
  always_comb begin
    ptr_nxt = grant_idx + 1'b1;
    if (int'(grant_idx) == p_nports - 1) begin
      ptr_nxt = '0;
    end
  end

  // Ready goes only to the granted port, and only when it can transfer.
  always_comb begin
    bus.in_rdy = '0;
    if (xfer) begin
      bus.in_rdy[grant_idx] = 1'b1;
    end
  end

  // Output stage and priority pointer; stalls and idle cycles hold everything
  // except out_val, which drops once a drained register is not refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_val <= 1'b0;
      bus.out_msg <= '0;
      bus.out_sel <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      bus.out_val <= 1'b1;
      bus.out_msg <= bus.in_msg[int'(grant_idx)*p_nbits +: p_nbits];
      bus.out_sel <= grant_idx;
      ptr         <= ptr_nxt;
    end else if (out_go) begin
      bus.out_val <= 1'b0;
    end
  end

  // At most one port may be told ready in any cycle.
  a_rdy_onehot0: assert property (@(posedge clk) $onehot0(bus.in_rdy));

endmodule

// File: tb/tb_vc_rr_arb_mux.sv
// Bench for vc_rr_arb_mux with N=4, 8-bit messages: directed steps followed by
// randomized traffic, checked against a reference model and a message queue.
module tb_vc_rr_arb_mux;
  localparam int NB = 8;
  localparam int NP = 4;
  localparam int SB = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_rr_arb_mux_if #(.p_nbits(NB), .p_nports(NP)) bus ();

  vc_rr_arb_mux #(.p_nbits(NB), .p_nports(NP)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Stimulus state.
  logic [NP-1:0] val;
  logic          ordy;
  logic [NB-1:0] msg [NP];

  // Reference model state.
  int            m_ptr;
  logic          m_val;
  logic [NB-1:0] m_msg;
  logic [SB-1:0] m_sel;
  logic [NB-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  logic [NP-1:0] acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.in_val  = val;
    bus.out_rdy = ordy;
    for (int i = 0; i < NP; i++) bus.in_msg[i*NB +: NB] = msg[i];
  endtask

  // Requester with the smallest cyclic distance from the priority pointer.
  function automatic int pick(input logic [NP-1:0] v, input int p);
    int best = -1;
    int bd   = NP;
    for (int i = 0; i < NP; i++) begin
      if (v[i] && ((i - p + NP) % NP) < bd) begin
        bd   = (i - p + NP) % NP;
        best = i;
      end
    end
    return best;
  endfunction

  // One clock cycle: apply inputs, check ready, advance model, check outputs.
  task automatic tick(output logic [NP-1:0] accepted);
    int            g;
    logic          go;
    logic [NP-1:0] er;
    @(negedge clk);
    drive();
    #1;
    go = !m_val || ordy;
    g  = pick(val, m_ptr);
    er = '0;
    if (g >= 0 && go && !rst) er[g] = 1'b1;
    check("in_rdy", {28'd0, bus.in_rdy}, {28'd0, er});
    if (!rst && bus.out_val === 1'b1 && ordy) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("sb_msg", {24'd0, bus.out_msg}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    if (rst) begin
      m_val = 1'b0; m_msg = '0; m_sel = '0; m_ptr = 0;
      exp_q.delete();
    end else if (er != '0) begin
      m_val = 1'b1; m_msg = msg[g]; m_sel = SB'(g); m_ptr = (g + 1) % NP;
      exp_q.push_back(msg[g]);
    end else if (go) begin
      m_val = 1'b0;
    end
    accepted = rst ? '0 : er;
    #1;
    check("out_val", {31'd0, bus.out_val}, {31'd0, m_val});
    check("out_msg", {24'd0, bus.out_msg}, {24'd0, m_msg});
    check("out_sel", {30'd0, bus.out_sel}, {30'd0, m_sel});
  endtask

  initial begin
    val  = '0;
    ordy = 1'b1;
    for (int i = 0; i < NP; i++) msg[i] = '0;
    m_ptr = 0; m_val = 1'b0; m_msg = '0; m_sel = '0;
    drive();

    // Reset held two cycles with nothing valid.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(acc);
      check("rst_rdy", {28'd0, bus.in_rdy}, 32'h0);
      check("rst_val", {31'd0, bus.out_val}, 32'h0);
      check("rst_msg", {24'd0, bus.out_msg}, 32'h0);
      check("rst_sel", {30'd0, bus.out_sel}, 32'h0);
    end
    rst = 1'b0;

    // Single requester on port 2.
    val = 4'b0100; msg[2] = 8'hA5;
    tick(acc);
    check("single_acc", {28'd0, acc}, 32'h4);
    check("single_val", {31'd0, bus.out_val}, 32'h1);
    check("single_msg", {24'd0, bus.out_msg}, 32'hA5);
    check("single_sel", {30'd0, bus.out_sel}, 32'h2);
    val = '0;

    // Pointer at 3: ports 0,1 valid -> port 0 wins, then port 1.
    val = 4'b0011; msg[0] = 8'h21; msg[1] = 8'h22;
    tick(acc);
    check("wrap_acc", {28'd0, acc}, 32'h1);
    check("wrap_sel", {30'd0, bus.out_sel}, 32'h0);
    msg[0] = 8'h23;
    tick(acc);
    check("skip_acc", {28'd0, acc}, 32'h2);
    check("skip_sel", {30'd0, bus.out_sel}, 32'h1);
    check("skip_msg", {24'd0, bus.out_msg}, 32'h22);
    val = '0;

    // Reset to bring the pointer back to 0.
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;

    // All valid, consumer always ready: strict rotation, no bubbles.
    for (int i = 0; i < NP; i++) msg[i] = 8'h10 + NB'(i);
    val = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick(acc);
      check("rr_val", {31'd0, bus.out_val}, 32'h1);
      check("rr_sel", {30'd0, bus.out_sel}, k % 4);
      check("rr_msg", {24'd0, bus.out_msg}, 32'h10 + (k % 4));
    end
    tick(acc);
    tick(acc);
    check("pre_bp_msg", {24'd0, bus.out_msg}, 32'h11);

    // Back-pressure while holding 0x11 from port 1.
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      check("bp_acc", {28'd0, acc}, 32'h0);
      check("bp_msg", {24'd0, bus.out_msg}, 32'h11);
      check("bp_sel", {30'd0, bus.out_sel}, 32'h1);
    end
    ordy = 1'b1;
    tick(acc);
    check("bp_release_sel", {30'd0, bus.out_sel}, 32'h2);
    check("bp_release_msg", {24'd0, bus.out_msg}, 32'h12);

    // Reset with 0x12 pending and a transfer available.
    rst = 1'b1;
    tick(acc);
    check("midrst_val", {31'd0, bus.out_val}, 32'h0);
    check("midrst_sel", {30'd0, bus.out_sel}, 32'h0);
    rst = 1'b0;
    tick(acc);
    check("postrst_sel", {30'd0, bus.out_sel}, 32'h0);
    check("postrst_msg", {24'd0, bus.out_msg}, 32'h10);
    val = '0;

    // Randomized traffic: requesters hold until accepted, random consumer stalls.
    for (int k = 0; k < 400; k++) begin
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) begin
        if (!val[i] && $urandom_range(0, 2) == 0) begin
          val[i] = 1'b1;
          msg[i] = NB'($urandom);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      tick(acc);
      val = val & ~acc;
    end
    rst = 1'b0;

    // Drain and confirm every accepted message came out.
    val  = '0;
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) tick(acc);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
